pll_cen_sequencer: RTL and testbench

//  Lock-qualified reset sequencer and multi-channel fractional clock-enable generator.

---
 rtl/pll_cen_sequencer.sv | 145 ++++++++++++++
 tb/tb_pll_cen_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_cen_sequencer.sv
// pll_cen_sequencer
//   Lock-qualified reset sequencer plus a bank of NCO clock-enable generators.
//   The PLL lock input is synchronised, must stay high for LOCK_STABLE+1
//   consecutive samples, and only then is the core reset released. While the
//   sequencer is running, each channel adds its increment to a phase
//   accumulator every clk and emits a one-cycle strobe on accumulator carry.
//
// Ports
//   clk        system clock (PLL output)
//   reset      asynchronous, active-high reset
//   pll_locked PLL lock indication, asynchronous to clk
//   inc_we     increment write strobe
//   inc_sel    channel index for the increment write
//   inc_data   new increment value
//   rst_out    synchronous reset to the core, active high
//   running    high while the sequencer is in RUN
//   cen        per-channel clock-enable strobes, one clk wide
module pll_cen_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int ACC_W       = 24,
  parameter int LOCK_STABLE = 1024,
  parameter logic [NUM_CH*ACC_W-1:0] INIT_INC = '0,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pll_locked,
  input  logic              inc_we,
  input  logic [SEL_W-1:0]  inc_sel,
  input  logic [ACC_W-1:0]  inc_data,
  output logic              rst_out,
  output logic              running,
  output logic [NUM_CH-1:0] cen
);

  localparam int CNT_W = $clog2(LOCK_STABLE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LOCK_STABLE);
  localparam logic [SEL_W:0]   NUM_CH_L = (SEL_W + 1)'(NUM_CH);

  typedef enum logic [1:0] {
    ST_LOST,
    ST_SETTLE,
    ST_RUN
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lock_s1, lock_s2;
  logic             run_nxt;
  logic [ACC_W-1:0] acc [NUM_CH];
  logic [ACC_W-1:0] inc [NUM_CH];

  // Two-flop synchroniser for the asynchronous lock input; only the second
  // stage is allowed to influence the state machine.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
    end else begin
      lock_s1 <= pll_locked;
      lock_s2 <= lock_s1;
    end
  end

  // Lock qualification: the counter is loaded with 1 on the first high
  // sample, so reaching LOCK_STABLE means LOCK_STABLE+1 good samples have
  // been seen. Any low sample drops straight back to LOST.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_LOST: begin
        if (lock_s2) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (!lock_s2) begin
          state_nxt = ST_LOST;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = ST_RUN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lock_s2) begin
          state_nxt = ST_LOST;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_LOST;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign run_nxt = (state_nxt == ST_RUN);

  // State register; rst_out and running are registered from the next state
  // so they always agree with the state held in the register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_LOST;
      cnt     <= '0;
      rst_out <= 1'b1;
      running <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rst_out <= !run_nxt;
      running <= run_nxt;
    end
  end

  // Phase accumulators advance on every edge that lands in RUN (including the
  // entry edge) and are cleared on the edge that leaves RUN, so all channels
  // start phase-aligned each time the sequencer re-enters RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
      cen <= '0;
    end else if (run_nxt) begin
      for (int i = 0; i < NUM_CH; i++)
        {cen[i], acc[i]} <= {1'b0, acc[i]} + {1'b0, inc[i]};
    end else begin
      for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
      cen <= '0;
    end
  end

  // Increment registers: writable in any state, out-of-range indices are
  // dropped, and the accumulators are never disturbed by a write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) inc[i] <= INIT_INC[i*ACC_W +: ACC_W];
    end else if (inc_we && ({1'b0, inc_sel} < NUM_CH_L)) begin
      inc[inc_sel] <= inc_data;
    end
  end

endmodule

// File: tb/tb_pll_cen_sequencer.sv
// tb_pll_cen_sequencer
//   Drives two sequencer instances side by side: a two-channel one and a
//   three-channel one (the latter has a 2-bit channel index, so an index of 3
//   is out of range for it). Expected outputs come from a reference model that
//   counts consecutive lock samples and tracks the total phase each channel
//   has accumulated since RUN was entered.
module tb_pll_cen_sequencer;

  localparam int LS = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pll_locked = 1'b0;
  logic       inc_we_a = 1'b0;
  logic [0:0] inc_sel_a = '0;
  logic       inc_we_b = 1'b0;
  logic [1:0] inc_sel_b = '0;
  logic [3:0] inc_data = '0;

  logic       rst_out_a, running_a;
  logic [1:0] cen_a;
  logic       rst_out_b, running_b;
  logic [2:0] cen_b;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model state
  int          streak = 0;
  int          streak_d = 0;
  int          old_streak = 0;
  bit          exp_run = 1'b0;
  logic [4:0]  exp_cen = '0;
  int unsigned tot [5];
  int unsigned inc_m [5];
  int unsigned nt = 0;

  wire [8:0] obs_vec = {cen_b, cen_a, running_b, rst_out_b, running_a, rst_out_a};
  wire [8:0] exp_vec = {exp_cen, exp_run, ~exp_run, exp_run, ~exp_run};

  pll_cen_sequencer #(
    .NUM_CH(2), .ACC_W(4), .LOCK_STABLE(LS), .INIT_INC({4'd8, 4'd4})
  ) dut_a (
    .clk(clk), .reset(reset), .pll_locked(pll_locked),
    .inc_we(inc_we_a), .inc_sel(inc_sel_a), .inc_data(inc_data),
    .rst_out(rst_out_a), .running(running_a), .cen(cen_a)
  );

  pll_cen_sequencer #(
    .NUM_CH(3), .ACC_W(4), .LOCK_STABLE(LS), .INIT_INC({4'd2, 4'd8, 4'd4})
  ) dut_b (
    .clk(clk), .reset(reset), .pll_locked(pll_locked),
    .inc_we(inc_we_b), .inc_sel(inc_sel_b), .inc_data(inc_data),
    .rst_out(rst_out_b), .running(running_b), .cen(cen_b)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  // Reference model: RUN holds after an edge when the lock samples taken two
  // edges earlier closed a run of LOCK_STABLE+1 consecutive highs. Each
  // channel strobes whenever its total accumulated phase crosses a multiple
  // of 16. Writes become visible on the following edge.
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        streak   = 0;
        streak_d = 0;
        exp_run  = 1'b0;
        exp_cen  = '0;
        for (int c = 0; c < 5; c++) tot[c] = 0;
        inc_m[0] = 4; inc_m[1] = 8;
        inc_m[2] = 4; inc_m[3] = 8; inc_m[4] = 2;
      end else begin
        old_streak = streak_d;
        streak_d   = streak;
        streak     = pll_locked ? streak + 1 : 0;
        exp_run    = (old_streak >= LS + 1);
        for (int c = 0; c < 5; c++) begin
          if (exp_run) begin
            nt         = tot[c] + inc_m[c];
            exp_cen[c] = ((nt / 16) != (tot[c] / 16));
            tot[c]     = nt;
          end else begin
            tot[c]     = 0;
            exp_cen[c] = 1'b0;
          end
        end
        if (inc_we_a) inc_m[inc_sel_a] = inc_data;
        if (inc_we_b && inc_sel_b < 2'd3) inc_m[2 + inc_sel_b] = inc_data;
      end
    end
  end

  // Advance one clock and return at the following falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    pll_locked = 1'b1;
    #1;
    vectors++;
    if (obs_vec !== 9'b000_00_0101) begin
      miscompares++;
      $display("[TB] FAIL reset_async: got %b expected %b", obs_vec, 9'b000_00_0101);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (obs_vec !== 9'b000_00_0101) begin
        miscompares++;
        $display("[TB] FAIL reset_held cyc %0d: got %b expected %b", cyc, obs_vec, 9'b000_00_0101);
      end
    end
  endtask

  task automatic test_lock_release();
    reset = 1'b0;
    for (int e = 0; e < 15; e++) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("[TB] FAIL release_model edge %0d: got %b expected %b", e, obs_vec, exp_vec);
      end
      if (e == 9 || e == 10) begin
        vectors++;
        if (rst_out_a !== (e == 9)) begin
          miscompares++;
          $display("[TB] FAIL release_edge edge %0d: got rst_out=%b expected %b", e, rst_out_a, (e == 9));
        end
      end
      if (e == 11 || e == 13) begin
        vectors++;
        if (cen_a !== ((e == 11) ? 2'b10 : 2'b11)) begin
          miscompares++;
          $display("[TB] FAIL first_strobe edge %0d: got cen=%b expected %b", e, cen_a, ((e == 11) ? 2'b10 : 2'b11));
        end
      end
    end
  endtask

  task automatic test_run_rates();
    int cnt [5];
    for (int c = 0; c < 5; c++) cnt[c] = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("[TB] FAIL rates_model cyc %0d: got %b expected %b", cyc, obs_vec, exp_vec);
      end
      for (int c = 0; c < 5; c++) cnt[c] += obs_vec[4 + c];
    end
    vectors++;
    if (cnt[0] != 8 || cnt[1] != 16 || cnt[2] != 8 || cnt[3] != 16 || cnt[4] != 4) begin
      miscompares++;
      $display("[TB] FAIL rates_count: got %0d/%0d/%0d/%0d/%0d expected 8/16/8/16/4",
               cnt[0], cnt[1], cnt[2], cnt[3], cnt[4]);
    end
  endtask

  task automatic test_lock_glitch();
    pll_locked = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    pll_locked = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("[TB] FAIL glitch_settle cyc %0d: got %b expected %b", cyc, obs_vec, exp_vec);
      end
    end
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    for (int e = 0; e < 16; e++) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("[TB] FAIL glitch_model edge %0d: got %b expected %b", e, obs_vec, exp_vec);
      end
      if (e == 9 || e == 10) begin
        vectors++;
        if (running_a !== (e == 10)) begin
          miscompares++;
          $display("[TB] FAIL glitch_restart edge %0d: got running=%b expected %b", e, running_a, (e == 10));
        end
      end
    end
  endtask

  task automatic test_lock_loss();
    pll_locked = 1'b0;
    for (int e = 0; e < 5; e++) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("[TB] FAIL loss_model edge %0d: got %b expected %b", e, obs_vec, exp_vec);
      end
      if (e == 1 || e == 2) begin
        vectors++;
        if ({running_a, rst_out_a} !== ((e == 1) ? 2'b10 : 2'b01) || (e == 2 && cen_a !== 2'b00)) begin
          miscompares++;
          $display("[TB] FAIL loss_timing edge %0d: got running=%b rst_out=%b cen=%b", e, running_a, rst_out_a, cen_a);
        end
      end
    end
    pll_locked = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("[TB] FAIL relock_model cyc %0d: got %b expected %b", cyc, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_writes();
    int cnt0;
    int cntb [3];
    inc_we_a = 1'b1; inc_sel_a = 1'b0; inc_data = 4'd15;
    tick();
    inc_we_a = 1'b0;
    cnt0 = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("[TB] FAIL write15_model cyc %0d: got %b expected %b", cyc, obs_vec, exp_vec);
      end
      cnt0 += cen_a[0];
    end
    vectors++;
    if (cnt0 != 30) begin
      miscompares++;
      $display("[TB] FAIL write15_count: got %0d expected 30", cnt0);
    end
    inc_we_a = 1'b1; inc_data = 4'd0;
    tick();
    inc_we_a = 1'b0;
    cnt0 = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      cnt0 += cen_a[0];
    end
    vectors++;
    if (cnt0 != 0) begin
      miscompares++;
      $display("[TB] FAIL write0_count: got %0d expected 0", cnt0);
    end
    inc_we_b = 1'b1; inc_sel_b = 2'd3; inc_data = 4'd0;
    tick();
    inc_we_b = 1'b0;
    for (int c = 0; c < 3; c++) cntb[c] = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("[TB] FAIL badsel_model cyc %0d: got %b expected %b", cyc, obs_vec, exp_vec);
      end
      for (int c = 0; c < 3; c++) cntb[c] += cen_b[c];
    end
    vectors++;
    if (cntb[0] != 4 || cntb[1] != 8 || cntb[2] != 2) begin
      miscompares++;
      $display("[TB] FAIL badsel_count: got %0d/%0d/%0d expected 4/8/2", cntb[0], cntb[1], cntb[2]);
    end
  endtask

  task automatic test_reset_mid_run();
    int cnt [5];
    inc_we_a = 1'b1; inc_sel_a = 1'b1; inc_data = 4'd1;
    inc_we_b = 1'b1; inc_sel_b = 2'd0;
    tick();
    inc_we_a = 1'b0; inc_we_b = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (obs_vec !== 9'b000_00_0101) begin
      miscompares++;
      $display("[TB] FAIL reset_midrun: got %b expected %b", obs_vec, 9'b000_00_0101);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("[TB] FAIL rerun_model cyc %0d: got %b expected %b", cyc, obs_vec, exp_vec);
      end
    end
    for (int c = 0; c < 5; c++) cnt[c] = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      for (int c = 0; c < 5; c++) cnt[c] += obs_vec[4 + c];
    end
    vectors++;
    if (cnt[0] != 8 || cnt[1] != 16 || cnt[2] != 8 || cnt[3] != 16 || cnt[4] != 4) begin
      miscompares++;
      $display("[TB] FAIL rerun_count: got %0d/%0d/%0d/%0d/%0d expected 8/16/8/16/4",
               cnt[0], cnt[1], cnt[2], cnt[3], cnt[4]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      pll_locked = ($urandom_range(0, 99) < 97);
      inc_we_a   = ($urandom_range(0, 9) == 0);
      inc_sel_a  = 1'($urandom_range(0, 1));
      inc_we_b   = ($urandom_range(0, 9) == 0);
      inc_sel_b  = 2'($urandom_range(0, 3));
      inc_data   = 4'($urandom_range(0, 15));
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("[TB] FAIL random_model cyc %0d: got %b expected %b", cyc, obs_vec, exp_vec);
      end
    end
    inc_we_a = 1'b0;
    inc_we_b = 1'b0;
  endtask

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_lock_release();
    test_run_rates();
    test_lock_glitch();
    test_lock_loss();
    test_writes();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
